// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780-class 8-bit text LCD controller with init sequence and continuous refresh
// Optional feature macro: LCD_HEX_EN (hex-nibble to ASCII conversion on buffer writes)
module lcd_text_ctrl #(
    parameter int COLS        = 16,
    parameter int LINES       = 2,
    parameter int PWRUP_DELAY = 70,
    parameter int CMD_GAP     = 30,
    parameter int E_HIGH      = 4,
    parameter int CLR_DELAY   = 200
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       WR_EN,
    input  logic       WR_LINE,
    input  logic [4:0] WR_COL,
    input  logic [7:0] WR_DATA,
    input  logic       WR_HEX,
    output logic       INIT_DONE,
    output logic       FRAME_DONE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int MAX_A  = (PWRUP_DELAY > CMD_GAP) ? PWRUP_DELAY : CMD_GAP;
    localparam int MAXLEN = (MAX_A > CLR_DELAY) ? MAX_A : CLR_DELAY;
    localparam int CW     = $clog2(MAXLEN + 1);

    localparam logic [CW-1:0] PWR_LAST  = CW'(PWRUP_DELAY - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CMD_GAP - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_DELAY - 1);
    localparam logic [CW-1:0] E_LAST    = CW'(E_HIGH);
    localparam logic [4:0]    LAST_COL  = 5'(COLS - 1);
    localparam logic          LAST_LINE = 1'(LINES - 1);
    localparam logic [1:0]    LINES_W   = 2'(LINES);
    localparam logic [5:0]    COLS_W    = 6'(COLS);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_FUNC_SET,
        ST_DISP_ON,
        ST_ENTRY,
        ST_CLEAR,
        ST_ADDR,
        ST_CHAR
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          line, line_n;
    logic [4:0]    col, col_n;
    logic          frame_n;
    logic          slot_last;
    logic          slot_rs;
    logic [7:0]    slot_data;
    logic          wr_ok;
    logic [7:0]    wr_val;
    logic [7:0]    mem [2][32];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        line_n    = line;
        col_n     = col;
        frame_n   = 1'b0;
        case (state)
            ST_PWRUP: slot_last = (cnt == PWR_LAST);
            ST_CLEAR: slot_last = (cnt == CLR_LAST);
            default:  slot_last = (cnt == GAP_LAST);
        endcase
        if (slot_last) begin
            cnt_n = '0;
            case (state)
                ST_PWRUP:    state_n = ST_FUNC_SET;
                ST_FUNC_SET: state_n = ST_DISP_ON;
                ST_DISP_ON:  state_n = ST_ENTRY;
                ST_ENTRY:    state_n = ST_CLEAR;
                ST_CLEAR: begin
                    state_n = ST_ADDR;
                    line_n  = 1'b0;
                end
                ST_ADDR: begin
                    state_n = ST_CHAR;
                    col_n   = '0;
                end
                ST_CHAR: begin
                    if (col == LAST_COL) begin
                        state_n = ST_ADDR;
                        if (line == LAST_LINE) begin
                            line_n  = 1'b0;
                            frame_n = 1'b1;
                        end else begin
                            line_n = 1'b1;
                        end
                    end else begin
                        col_n = col + 5'd1;
                    end
                end
                default: state_n = ST_PWRUP;
            endcase
        end
    end

    // Bus contents for the slot being entered; read with the pre-write buffer value.
    always_comb begin
        slot_rs   = (state_n == ST_CHAR);
        slot_data = 8'h00;
        case (state_n)
            ST_FUNC_SET: slot_data = (LINES == 2) ? 8'h38 : 8'h30;
            ST_DISP_ON:  slot_data = 8'h0C;
            ST_ENTRY:    slot_data = 8'h06;
            ST_CLEAR:    slot_data = 8'h01;
            ST_ADDR:     slot_data = line_n ? 8'hC0 : 8'h80;
            ST_CHAR:     slot_data = mem[line_n][col_n];
            default:     slot_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            state <= ST_PWRUP;
            cnt   <= '0;
            line  <= 1'b0;
            col   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            line  <= line_n;
            col   <= col_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            INIT_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            LCD_E <= (state_n != ST_PWRUP) && (cnt_n != '0) && (cnt_n <= E_LAST);
            if ((state_n != ST_PWRUP) && (cnt_n == '0)) begin
                LCD_RS   <= slot_rs;
                LCD_DATA <= slot_data;
            end
            if (state_n == ST_ADDR) begin
                INIT_DONE <= 1'b1;
            end
            FRAME_DONE <= frame_n;
        end
    end

    assign LCD_RW = 1'b0;

    assign wr_ok = WR_EN && ({1'b0, WR_LINE} < LINES_W) && ({1'b0, WR_COL} < COLS_W);

`ifdef LCD_HEX_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign wr_val = WR_HEX ? hex_ascii(WR_DATA[3:0]) : WR_DATA;
`else
    logic unused_wr_hex;
    assign unused_wr_hex = WR_HEX;
    assign wr_val        = WR_DATA;
`endif

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            for (int l = 0; l < 2; l++) begin
                for (int c = 0; c < 32; c++) begin
                    mem[l][c] <= 8'h20;
                end
            end
        end else if (wr_ok) begin
            mem[WR_LINE][WR_COL] <= wr_val;
        end
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb/tb_lcd_text_ctrl.sv - scoreboard bench for lcd_text_ctrl (hex expectations follow LCD_HEX_EN)
`timescale 1ns/1ps
module tb_lcd_text_ctrl;
    localparam int COLS = 16;
    localparam int GAP  = 30;
    localparam int CLR  = 200;
    localparam int PWR  = 70;
    localparam int EH   = 4;
`ifdef LCD_HEX_EN
    localparam logic [7:0] HEX_B = 8'h42;
    localparam logic [7:0] HEX_7 = 8'h37;
`else
    localparam logic [7:0] HEX_B = 8'h0B;
    localparam logic [7:0] HEX_7 = 8'h07;
`endif

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic       WR_EN = 1'b0;
    logic       WR_LINE = 1'b0;
    logic [4:0] WR_COL = '0;
    logic [7:0] WR_DATA = '0;
    logic       WR_HEX = 1'b0;
    logic       INIT_DONE, FRAME_DONE, LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
        int         gap;
    } slot_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         prev_t = 0;
    int         last_t = 0;
    int         init_rise = -1;
    logic       init_prev = 1'b0;
    slot_t      sb[$];
    int         fd_q[$];
    logic [7:0] model [2][COLS];

    lcd_text_ctrl dut (
        .CLK(CLK), .RESETN(RESETN), .WR_EN(WR_EN), .WR_LINE(WR_LINE),
        .WR_COL(WR_COL), .WR_DATA(WR_DATA), .WR_HEX(WR_HEX),
        .INIT_DONE(INIT_DONE), .FRAME_DONE(FRAME_DONE), .LCD_E(LCD_E),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (FRAME_DONE) fd_q.push_back(cyc);
        if (INIT_DONE && !init_prev) init_rise <= cyc;
        init_prev <= INIT_DONE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < COLS; c++) model[l][c] = 8'h20;
    endtask

    task automatic wr(input logic line, input logic [4:0] col, input logic [7:0] d,
                      input logic hex, input logic [7:0] stored);
        @(negedge CLK);
        WR_EN = 1'b1; WR_LINE = line; WR_COL = col; WR_DATA = d; WR_HEX = hex;
        @(posedge CLK); #1;
        WR_EN = 1'b0; WR_HEX = 1'b0;
        if (int'(col) < COLS) model[line][col] = stored;
    endtask

    task automatic get_slot(output int t, output logic ok);
        int n = 0;
        while (LCD_E && n < 400) begin @(posedge CLK); #1; n++; end
        while (!LCD_E && n < 400) begin @(posedge CLK); #1; n++; end
        t  = cyc;
        ok = (n < 400);
    endtask

    task automatic pop_check(input string tag);
        slot_t e;
        int    t;
        logic  ok;
        get_slot(t, ok);
        check({tag, "_wait"}, {31'b0, ok}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rs"}, {31'b0, LCD_RS}, {31'b0, e.rs});
            check({tag, "_data"}, {24'b0, LCD_DATA}, {24'b0, e.d});
            check({tag, "_gap"}, t - prev_t, e.gap);
            check({tag, "_rw"}, {31'b0, LCD_RW}, 32'd0);
        end
        prev_t = t;
        last_t = t;
    endtask

    task automatic run_init();
        int h;
        sb.push_back('{1'b0, 8'h38, PWR + 1});
        sb.push_back('{1'b0, 8'h0C, GAP});
        sb.push_back('{1'b0, 8'h06, GAP});
        sb.push_back('{1'b0, 8'h01, GAP});
        pop_check("func_set");
        h = 0;
        while (LCD_E && h < 20) begin h++; @(posedge CLK); #1; end
        check("e_high_len", h, EH);
        pop_check("disp_on");
        pop_check("entry");
        pop_check("clear");
        check("init_low_in_clear", {31'b0, INIT_DONE}, 32'd0);
    endtask

    task automatic run_frame(input logic first, input logic collide);
        for (int l = 0; l < 2; l++) begin
            sb.push_back('{1'b0, (l == 0) ? 8'h80 : 8'hC0, (first && l == 0) ? CLR : GAP});
            for (int c = 0; c < COLS; c++) sb.push_back('{1'b1, model[l][c], GAP});
        end
        for (int l = 0; l < 2; l++) begin
            pop_check(l == 0 ? "addr0" : "addr1");
            if (l == 0) begin
                if (first) begin
                    check("init_rise", init_rise, last_t - 1);
                    check("no_frame_done", fd_q.size(), 0);
                end else begin
                    check("frame_done_count", fd_q.size(), 1);
                    if (fd_q.size() > 0) check("frame_done_cycle", fd_q.pop_front(), last_t - 1);
                end
                if (collide) begin
                    repeat (GAP - 2) @(posedge CLK);
                    wr(1'b0, 5'd0, 8'h66, 1'b0, 8'h66);
                end
            end
            for (int c = 0; c < COLS; c++) pop_check(l == 0 ? "char0" : "char1");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        RESETN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_e", {31'b0, LCD_E}, 32'd0);
        check("rst_rs", {31'b0, LCD_RS}, 32'd0);
        check("rst_rw", {31'b0, LCD_RW}, 32'd0);
        check("rst_data", {24'b0, LCD_DATA}, 32'd0);
        check("rst_init", {31'b0, INIT_DONE}, 32'd0);
        check("rst_fd", {31'b0, FRAME_DONE}, 32'd0);
        prev_t = cyc;
        @(negedge CLK);
        RESETN = 1'b0;

        run_init();
        run_frame(1'b1, 1'b0);

        wr(1'b1, 5'd3, 8'h41, 1'b0, 8'h41);
        wr(1'b0, 5'd16, 8'h5A, 1'b0, 8'h00);
        wr(1'b1, 5'd31, 8'h5B, 1'b0, 8'h00);
        wr(1'b0, 5'd0, 8'h11, 1'b0, 8'h11);
        wr(1'b0, 5'd0, 8'h12, 1'b0, 8'h12);
        wr(1'b0, 5'd5, 8'h0B, 1'b1, HEX_B);
        wr(1'b0, 5'd6, 8'h07, 1'b1, HEX_7);
        wr(1'b0, 5'd15, 8'h7E, 1'b0, 8'h7E);
        run_frame(1'b0, 1'b0);
        run_frame(1'b0, 1'b1);
        run_frame(1'b0, 1'b0);

        sb.push_back('{1'b0, 8'h80, GAP});
        pop_check("pre_rst_addr");
        check("pre_rst_fd_count", fd_q.size(), 1);
        if (fd_q.size() > 0) check("pre_rst_fd_cycle", fd_q.pop_front(), last_t - 1);
        sb.push_back('{1'b1, model[0][0], GAP});
        pop_check("pre_rst_char");
        check("pre_rst_e_high", {31'b0, LCD_E}, 32'd1);
        @(negedge CLK);
        RESETN = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_e", {31'b0, LCD_E}, 32'd0);
        check("mid_rst_data", {24'b0, LCD_DATA}, 32'd0);
        check("mid_rst_rs", {31'b0, LCD_RS}, 32'd0);
        check("mid_rst_init", {31'b0, INIT_DONE}, 32'd0);
        prev_t = cyc;
        @(negedge CLK);
        RESETN = 1'b0;
        clear_model();
        wr(1'b0, 5'd1, 8'h55, 1'b0, 8'h55);
        run_init();
        run_frame(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
